// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size and fault
// encodings, FSM state encoding, default memory map and load extension.
package lsu_pkg;

    // Default memory map (byte addresses, all bases 4-byte aligned)
    localparam logic [31:0] LSU_ROM_BASE    = 32'h0000_0000;
    localparam logic [31:0] LSU_ROM_SIZE    = 32'h0002_0000;
    localparam logic [31:0] LSU_SRAM_BASE   = 32'h0002_0000;
    localparam logic [31:0] LSU_SRAM_SIZE   = 32'h0001_0000;
    localparam logic [31:0] LSU_PERIPH_BASE = 32'h0003_0000;
    localparam logic [31:0] LSU_PERIPH_SIZE = 32'h0001_0000;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        FAULT_NONE      = 2'b00,
        FAULT_ALIGN     = 2'b01,
        FAULT_UNMAPPED  = 2'b10,
        FAULT_ROM_WRITE = 2'b11
    } lsu_fault_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } lsu_state_e;

    // Right-justify a loaded byte/halfword and fill the upper bits with
    // zeros or copies of its top bit; words pass through untouched.
    function automatic logic [31:0] lsu_extend(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic        sgn);
        logic [31:0] res;
        res = word;
        case (size)
            SIZE_BYTE: res = {{24{sgn & word[7]}},  word[7:0]};
            SIZE_HALF: res = {{16{sgn & word[15]}}, word[15:0]};
            default:   res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response handshake plus memory bus of the load/store unit.
// master = execute stage and memory model side, slave = the unit itself.
interface lsu_if;
    // request from execute stage
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    // response pulse
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic [1:0]  rsp_fault_code;
    // unified memory port
    logic        mem_w_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_w_data;
    logic [31:0] mem_r_data;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  mem_r_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_fault_code,
        output mem_w_en, mem_addr, mem_w_data
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output mem_r_data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_fault_code,
        input  mem_w_en, mem_addr, mem_w_data
    );
endinterface

// File: rtl/lsu_addr_check.sv
// Combinational alignment and memory-map check. Kept free of any state
// so an instruction-fetch unit can reuse it as-is.
module lsu_addr_check
    import lsu_pkg::*;
#(
    parameter logic [31:0] ROM_BASE    = LSU_ROM_BASE,
    parameter logic [31:0] ROM_SIZE    = LSU_ROM_SIZE,
    parameter logic [31:0] SRAM_BASE   = LSU_SRAM_BASE,
    parameter logic [31:0] SRAM_SIZE   = LSU_SRAM_SIZE,
    parameter logic [31:0] PERIPH_BASE = LSU_PERIPH_BASE,
    parameter logic [31:0] PERIPH_SIZE = LSU_PERIPH_SIZE
) (
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic        write,
    output logic        fault,
    output logic [1:0]  fault_code
);

    logic misaligned;
    logic in_rom;
    logic in_sram;
    logic in_periph;
    logic [31:0] rom_off;
    logic [31:0] sram_off;
    logic [31:0] periph_off;

    // Offsets wrap modulo 2^32, so an address below a base becomes huge and
    // fails the unsigned size compare; no special case for the top of memory.
    assign rom_off    = addr - ROM_BASE;
    assign sram_off   = addr - SRAM_BASE;
    assign periph_off = addr - PERIPH_BASE;
    assign in_rom     = rom_off    < ROM_SIZE;
    assign in_sram    = sram_off   < SRAM_SIZE;
    assign in_periph  = periph_off < PERIPH_SIZE;

    // Classify the access with size/alignment taking priority over the map
    always_comb begin
        misaligned = 1'b0;
        case (size)
            SIZE_HALF:    misaligned = addr[0];
            SIZE_WORD:    misaligned = (addr[1:0] != 2'b00);
            SIZE_ILLEGAL: misaligned = 1'b1;
            default:      misaligned = 1'b0;
        endcase

        fault      = 1'b1;
        fault_code = FAULT_NONE;
        if (misaligned) begin
            fault_code = FAULT_ALIGN;
        end else if (!(in_rom || in_sram || in_periph)) begin
            fault_code = FAULT_UNMAPPED;
        end else if (write && in_rom) begin
            fault_code = FAULT_ROM_WRITE;
        end else begin
            fault = 1'b0;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, alignment/map check on accept,
// sign/zero-extended loads, read-modify-write for sub-word stores, and a
// single-cycle response pulse. All bus outputs are registered.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter logic [31:0] ROM_BASE    = LSU_ROM_BASE,
    parameter logic [31:0] ROM_SIZE    = LSU_ROM_SIZE,
    parameter logic [31:0] SRAM_BASE   = LSU_SRAM_BASE,
    parameter logic [31:0] SRAM_SIZE   = LSU_SRAM_SIZE,
    parameter logic [31:0] PERIPH_BASE = LSU_PERIPH_BASE,
    parameter logic [31:0] PERIPH_SIZE = LSU_PERIPH_SIZE
) (
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);

    lsu_state_e  state_reg;
    logic        write_reg;
    logic [1:0]  size_reg;
    logic        signed_reg;
    logic [31:0] wdata_reg;

    logic        req_ready_reg;
    logic        rsp_valid_reg;
    logic [31:0] rsp_rdata_reg;
    logic        rsp_fault_reg;
    logic [1:0]  rsp_fault_code_reg;
    logic        mem_w_en_reg;
    logic [31:0] mem_addr_reg;
    logic [31:0] mem_w_data_reg;

    logic        chk_fault;
    logic [1:0]  chk_code;
    logic [3:0]  lane_en;
    logic [31:0] merged_word;
    logic [31:0] load_data;

    lsu_addr_check #(
        .ROM_BASE    (ROM_BASE),
        .ROM_SIZE    (ROM_SIZE),
        .SRAM_BASE   (SRAM_BASE),
        .SRAM_SIZE   (SRAM_SIZE),
        .PERIPH_BASE (PERIPH_BASE),
        .PERIPH_SIZE (PERIPH_SIZE)
    ) u_addr_check (
        .addr       (bus.req_addr),
        .size       (bus.req_size),
        .write      (bus.req_write),
        .fault      (chk_fault),
        .fault_code (chk_code)
    );

    // Byte lanes taken from the store data; the remaining lanes keep the
    // word read back from memory so the full-word write is harmless.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_en[gi] = (gi == 0)
                              || ((gi == 1) && (size_reg == SIZE_HALF))
                              || (size_reg == SIZE_WORD);
            assign merged_word[gi*8 +: 8] = lane_en[gi] ? wdata_reg[gi*8 +: 8]
                                                        : bus.mem_r_data[gi*8 +: 8];
        end
    endgenerate

    assign load_data = lsu_extend(bus.mem_r_data, size_reg, signed_reg);

    // Control FSM; every output register is loaded on the edge that enters
    // the state it belongs to, so outputs never glitch combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg          <= ST_IDLE;
            write_reg          <= 1'b0;
            size_reg           <= 2'b00;
            signed_reg         <= 1'b0;
            wdata_reg          <= 32'h0;
            req_ready_reg      <= 1'b1;
            rsp_valid_reg      <= 1'b0;
            rsp_rdata_reg      <= 32'h0;
            rsp_fault_reg      <= 1'b0;
            rsp_fault_code_reg <= FAULT_NONE;
            mem_w_en_reg       <= 1'b0;
            mem_addr_reg       <= 32'h0;
            mem_w_data_reg     <= 32'h0;
        end else begin
            rsp_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.req_valid && req_ready_reg) begin
                        write_reg     <= bus.req_write;
                        size_reg      <= bus.req_size;
                        signed_reg    <= bus.req_signed;
                        wdata_reg     <= bus.req_wdata;
                        req_ready_reg <= 1'b0;
                        if (chk_fault) begin
                            state_reg          <= ST_RESP;
                            rsp_valid_reg      <= 1'b1;
                            rsp_rdata_reg      <= 32'h0;
                            rsp_fault_reg      <= 1'b1;
                            rsp_fault_code_reg <= chk_code;
                        end else if (bus.req_write && (bus.req_size == SIZE_WORD)) begin
                            state_reg      <= ST_WRITE;
                            mem_w_en_reg   <= 1'b1;
                            mem_addr_reg   <= bus.req_addr;
                            mem_w_data_reg <= bus.req_wdata;
                        end else begin
                            // loads and sub-word stores both read first
                            state_reg    <= ST_READ;
                            mem_addr_reg <= bus.req_addr;
                        end
                    end
                end
                ST_READ: begin
                    if (write_reg) begin
                        state_reg      <= ST_WRITE;
                        mem_w_en_reg   <= 1'b1;
                        mem_w_data_reg <= merged_word;
                    end else begin
                        state_reg          <= ST_RESP;
                        mem_addr_reg       <= 32'h0;
                        rsp_valid_reg      <= 1'b1;
                        rsp_rdata_reg      <= load_data;
                        rsp_fault_reg      <= 1'b0;
                        rsp_fault_code_reg <= FAULT_NONE;
                    end
                end
                ST_WRITE: begin
                    state_reg          <= ST_RESP;
                    mem_w_en_reg       <= 1'b0;
                    mem_addr_reg       <= 32'h0;
                    mem_w_data_reg     <= 32'h0;
                    rsp_valid_reg      <= 1'b1;
                    rsp_rdata_reg      <= 32'h0;
                    rsp_fault_reg      <= 1'b0;
                    rsp_fault_code_reg <= FAULT_NONE;
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    req_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready      = req_ready_reg;
    assign bus.rsp_valid      = rsp_valid_reg;
    assign bus.rsp_rdata      = rsp_rdata_reg;
    assign bus.rsp_fault      = rsp_fault_reg;
    assign bus.rsp_fault_code = rsp_fault_code_reg;
    assign bus.mem_w_en       = mem_w_en_reg;
    assign bus.mem_addr       = mem_addr_reg;
    assign bus.mem_w_data     = mem_w_data_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit: a driver issues requests and
// pushes the hand-computed response into a scoreboard queue; a monitor
// pops and compares whenever rsp_valid is seen.
module tb_load_store_unit;
    import lsu_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        fault;
        logic [1:0]  code;
        int          acc;
        int          lat;
    } exp_t;

    logic  clk;
    logic  rst;
    lsu_if bus ();

    int    cyc;
    int    nvec;
    int    nerr;
    exp_t  sb[$];

    bit [7:0] mem [0:32'h3FFFF];
    bit       loaded;
    int       we_count;
    int       we_cyc;
    logic [31:0] we_data;

    load_store_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: combinational little-endian read, 4-byte write per edge
    function automatic logic [31:0] rd_word(input logic [31:0] a);
        logic [17:0] i;
        i = a[17:0];
        return {mem[i + 18'd3], mem[i + 18'd2], mem[i + 18'd1], mem[i]};
    endfunction

    assign bus.mem_r_data = rd_word(bus.mem_addr);

    always @(posedge clk) begin
        if (rst && !loaded) begin
            loaded <= 1'b1;
            mem[18'h000FA] <= 8'hFF; mem[18'h000FB] <= 8'hDC;
            mem[18'h000FC] <= 8'hBA; mem[18'h000FD] <= 8'h98;
            mem[18'h000FE] <= 8'h00; mem[18'h000FF] <= 8'h00;
            mem[18'h20010] <= 8'h44; mem[18'h20011] <= 8'h33;
            mem[18'h20012] <= 8'h22; mem[18'h20013] <= 8'h11;
            mem[18'h20020] <= 8'h88; mem[18'h20021] <= 8'h77;
            mem[18'h20022] <= 8'h66; mem[18'h20023] <= 8'h55;
        end else if (bus.mem_w_en) begin
            mem[bus.mem_addr[17:0]]         <= bus.mem_w_data[7:0];
            mem[bus.mem_addr[17:0] + 18'd1] <= bus.mem_w_data[15:8];
            mem[bus.mem_addr[17:0] + 18'd2] <= bus.mem_w_data[23:16];
            mem[bus.mem_addr[17:0] + 18'd3] <= bus.mem_w_data[31:24];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Write-strobe watcher for store timing and "never written" checks
    always @(negedge clk) begin
        if (bus.mem_w_en) begin
            we_count <= we_count + 1;
            we_cyc   <= cyc;
            we_data  <= bus.mem_w_data;
        end
    end

    // Response monitor / scoreboard
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("rsp %s: rdata=%h fault=%0d code=%0d cycle=%0d", e.name,
                         bus.rsp_rdata, bus.rsp_fault, bus.rsp_fault_code, cyc - e.acc);
                chk({e.name, "_rdata"}, bus.rsp_rdata, e.rdata);
                chk({e.name, "_fault"}, {31'd0, bus.rsp_fault}, {31'd0, e.fault});
                chk({e.name, "_code"},  {30'd0, bus.rsp_fault_code}, {30'd0, e.code});
                chk({e.name, "_lat"},   cyc, e.acc + e.lat);
            end
        end
    end

    // Present a request at a negedge, wait for acceptance, return at the
    // negedge after the accept edge. acc = cycle in which it was accepted.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] e_rdata, input logic e_fault,
                         input logic [1:0] e_code, input int lat, input bit hold,
                         input bit expect_rsp, input string nm, output int acc);
        int n;
        exp_t e;
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_size   = sz;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc;
        if (expect_rsp) begin
            e.name = nm; e.rdata = e_rdata; e.fault = e_fault;
            e.code = e_code; e.acc = acc; e.lat = lat;
            sb.push_back(e);
        end
        @(negedge clk);
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("rsp_timeout", sb.size(), 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2, acc, we0;
        cyc = 0; nvec = 0; nerr = 0;
        we_count = 0; we_cyc = 0; we_data = 0; loaded = 1'b0;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

        repeat (3) @(negedge clk);
        chk("rst_req_ready",  {31'd0, bus.req_ready}, 32'd1);
        chk("rst_rsp_valid",  {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_rdata",  bus.rsp_rdata, 32'd0);
        chk("rst_rsp_fault",  {31'd0, bus.rsp_fault}, 32'd0);
        chk("rst_fault_code", {30'd0, bus.rsp_fault_code}, 32'd0);
        chk("rst_mem_w_en",   {31'd0, bus.mem_w_en}, 32'd0);
        chk("rst_mem_addr",   bus.mem_addr, 32'd0);
        chk("rst_mem_w_data", bus.mem_w_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Loads with extension
        issue(0, SIZE_HALF, 1, 32'h000000FA, 0, 32'hFFFFDCFF, 0, 2'd0, 2, 0, 1, "ld_h_s", acc);
        issue(0, SIZE_HALF, 0, 32'h000000FA, 0, 32'h0000DCFF, 0, 2'd0, 2, 0, 1, "ld_h_u", acc);
        issue(0, SIZE_BYTE, 1, 32'h000000FD, 0, 32'hFFFFFF98, 0, 2'd0, 2, 0, 1, "ld_b_s", acc);
        issue(0, SIZE_BYTE, 0, 32'h000000FD, 0, 32'h00000098, 0, 2'd0, 2, 0, 1, "ld_b_u", acc);
        issue(0, SIZE_WORD, 1, 32'h000000FC, 0, 32'h000098BA, 0, 2'd0, 2, 0, 1, "ld_w", acc);
        drain();

        // Byte store: read-modify-write, strobe only in the third cycle
        we0 = we_count;
        issue(1, SIZE_BYTE, 0, 32'h00020010, 32'h000000AB, 32'h0, 0, 2'd0, 3, 0, 1, "st_b", acc);
        drain();
        chk("st_b_we_count", we_count - we0, 32'd1);
        chk("st_b_we_cycle", we_cyc, acc + 2);
        chk("st_b_we_data",  we_data, 32'h112233AB);
        issue(0, SIZE_WORD, 0, 32'h00020010, 0, 32'h112233AB, 0, 2'd0, 2, 0, 1, "ld_after_st_b", acc);
        drain();

        // Faults: no memory writes may occur
        we0 = we_count;
        issue(1, SIZE_WORD, 0, 32'h00000100, 32'h12345678, 32'h0, 1, 2'd3, 1, 0, 1, "st_rom", acc);
        issue(1, SIZE_WORD, 0, 32'h00000102, 32'h12345678, 32'h0, 1, 2'd1, 1, 0, 1, "st_rom_misal", acc);
        issue(0, SIZE_HALF, 0, 32'h00020001, 0, 32'h0, 1, 2'd1, 1, 0, 1, "ld_h_misal", acc);
        issue(0, SIZE_WORD, 0, 32'h00040000, 0, 32'h0, 1, 2'd2, 1, 0, 1, "ld_unmapped", acc);
        issue(0, SIZE_ILLEGAL, 0, 32'h00020000, 0, 32'h0, 1, 2'd1, 1, 0, 1, "ld_size3", acc);
        issue(0, SIZE_WORD, 0, 32'hFFFFFFFC, 0, 32'h0, 1, 2'd2, 1, 0, 1, "ld_top", acc);
        drain();
        chk("fault_no_write", we_count - we0, 32'd0);

        // Last peripheral byte is mapped
        issue(0, SIZE_BYTE, 1, 32'h0003FFFF, 0, 32'h0, 0, 2'd0, 2, 0, 1, "ld_periph_end", acc);
        // Word store to SRAM: strobe in the cycle after accept
        issue(1, SIZE_WORD, 0, 32'h00020014, 32'hCAFEBABE, 32'h0, 0, 2'd0, 2, 0, 1, "st_w", acc);
        drain();
        chk("st_w_we_cycle", we_cyc, acc + 1);
        chk("st_w_we_data",  we_data, 32'hCAFEBABE);
        issue(0, SIZE_BYTE, 1, 32'h00020017, 0, 32'hFFFFFFCA, 0, 2'd0, 2, 0, 1, "ld_b_top", acc);
        drain();

        // Reset during the write cycle of a halfword store
        issue(1, SIZE_HALF, 0, 32'h00020020, 32'h00001234, 32'h0, 0, 2'd0, 3, 0, 0, "st_h_rst", acc);
        @(negedge clk);
        #2;
        chk("rst_mid_pre_we", {31'd0, bus.mem_w_en}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_we",        {31'd0, bus.mem_w_en}, 32'd0);
        chk("rst_mid_ready",     {31'd0, bus.req_ready}, 32'd1);
        chk("rst_mid_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(0, SIZE_WORD, 0, 32'h00020020, 0, 32'h55667788, 0, 2'd0, 2, 0, 1, "ld_after_rst", acc);
        issue(1, SIZE_HALF, 0, 32'h00020020, 32'h0000BEEF, 32'h0, 0, 2'd0, 3, 0, 1, "st_h", acc);
        issue(0, SIZE_HALF, 1, 32'h00020020, 0, 32'hFFFFBEEF, 0, 2'd0, 2, 0, 1, "ld_h_after_st", acc);
        issue(0, SIZE_WORD, 0, 32'h00020020, 0, 32'h5566BEEF, 0, 2'd0, 2, 0, 1, "ld_w_after_st", acc);
        drain();

        // Back-to-back word loads with req_valid held high
        issue(0, SIZE_WORD, 0, 32'h000000FC, 0, 32'h000098BA, 0, 2'd0, 2, 1, 1, "b2b_0", a0);
        issue(0, SIZE_WORD, 0, 32'h00020010, 0, 32'h112233AB, 0, 2'd0, 2, 1, 1, "b2b_1", a1);
        issue(0, SIZE_WORD, 0, 32'h00020014, 0, 32'hCAFEBABE, 0, 2'd0, 2, 0, 1, "b2b_2", a2);
        drain();
        chk("b2b_spacing_01", a1 - a0, 32'd3);
        chk("b2b_spacing_12", a2 - a1, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
